decode_stage: RTL

- Registered, handshaked instruction-decode stage for the 32-bit simple processor. Sits between fetch and execute.
- Accepts one raw instruction per transfer and splits it into fields. Produces a one-hot operation class, a sign-extended immediate and the source-register read indices.
- Holds the decoded result in a pipeline register with valid/ready backpressure, flush, and a load-use interlock.

---
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake bundle for decode_stage.
// master: the fetch and execute side (drives in_*, out_ready, samples decoded fields).
// slave : the decode stage itself.
interface decode_stage_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TARGET_WIDTH = 27
);
    // fetch -> decode
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_instr;
    logic [31:0]             in_pc;

    // decode -> execute
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_pc;
    logic [4:0]              opcode;
    logic [4:0]              rd;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              shamt;
    logic [4:0]              aluop;
    logic [DATA_WIDTH-1:0]   imm;
    logic [TARGET_WIDTH-1:0] target;
    logic [15:0]             op_class;
    logic                    illegal;
    logic [4:0]              src_a;
    logic [4:0]              src_b;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs, rt, shamt, aluop,
               imm, target, op_class, illegal, src_a, src_b
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs, rt, shamt, aluop,
               imm, target, op_class, illegal, src_a, src_b
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: splits a raw 32-bit instruction into
// fields, one-hot op class, sign-extended immediate and register read indices,
// held in a single-entry valid/ready register with flush and load-use stall.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   flush          drop the held entry and anything accepted this cycle
//   ex_load_valid  execute holds a lw
//   ex_load_rd     destination register of that lw
//   bus            decode_stage_if.slave (in_* from fetch, out_*/fields to execute)
module decode_stage #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TARGET_WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             ex_load_valid,
    input  logic [4:0]       ex_load_rd,
    decode_stage_if.slave    bus
);
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CLASS_W = 16;

    // one-hot op_class bit positions
    localparam int unsigned C_ADD  = 0;
    localparam int unsigned C_SUB  = 1;
    localparam int unsigned C_AND  = 2;
    localparam int unsigned C_OR   = 3;
    localparam int unsigned C_SLL  = 4;
    localparam int unsigned C_SRA  = 5;
    localparam int unsigned C_ADDI = 6;
    localparam int unsigned C_SW   = 7;
    localparam int unsigned C_LW   = 8;
    localparam int unsigned C_J    = 9;
    localparam int unsigned C_BNE  = 10;
    localparam int unsigned C_JAL  = 11;
    localparam int unsigned C_JR   = 12;
    localparam int unsigned C_BLT  = 13;
    localparam int unsigned C_BEX  = 14;
    localparam int unsigned C_SETX = 15;

    // bex reads the status register
    localparam logic [REG_W-1:0] REG_STATUS = REG_W'(30);

    if (DATA_WIDTH < 17) begin : g_bad_data_width
        $error("decode_stage: DATA_WIDTH must be >= 17");
    end
    if (TARGET_WIDTH > 27) begin : g_bad_target_width
        $error("decode_stage: TARGET_WIDTH must be <= 27");
    end

    // field extraction
    logic [REG_W-1:0]        opcode_d, rd_d, rs_d, rt_d, shamt_d, aluop_d;
    logic [DATA_WIDTH-1:0]   imm_d;
    logic [TARGET_WIDTH-1:0] target_d;

    assign opcode_d = bus.in_instr[31:27];
    assign rd_d     = bus.in_instr[26:22];
    assign rs_d     = bus.in_instr[21:17];
    assign rt_d     = bus.in_instr[16:12];
    assign shamt_d  = bus.in_instr[11:7];
    assign aluop_d  = bus.in_instr[6:2];
    assign imm_d    = DATA_WIDTH'($signed(bus.in_instr[16:0]));
    assign target_d = bus.in_instr[TARGET_WIDTH-1:0];

    // class and read-index decode
    logic [CLASS_W-1:0] class_d;
    logic               illegal_d;
    logic [REG_W-1:0]   src_a_d, src_b_d;

    always_comb begin
        class_d   = '0;
        illegal_d = 1'b0;
        src_a_d   = '0;
        src_b_d   = '0;
        case (opcode_d)
            5'b00000: begin
                case (aluop_d)
                    5'b00000: class_d[C_ADD] = 1'b1;
                    5'b00001: class_d[C_SUB] = 1'b1;
                    5'b00010: class_d[C_AND] = 1'b1;
                    5'b00011: class_d[C_OR]  = 1'b1;
                    5'b00100: class_d[C_SLL] = 1'b1;
                    5'b00101: class_d[C_SRA] = 1'b1;
                    default:  illegal_d      = 1'b1;
                endcase
                if (!illegal_d) begin
                    src_a_d = rs_d;
                    src_b_d = rt_d;
                end
            end
            5'b00101: begin class_d[C_ADDI] = 1'b1; src_a_d = rs_d; end
            5'b00111: begin class_d[C_SW]   = 1'b1; src_a_d = rd_d; src_b_d = rs_d; end
            5'b01000: begin class_d[C_LW]   = 1'b1; src_a_d = rs_d; end
            5'b00001: class_d[C_J]   = 1'b1;
            5'b00010: begin class_d[C_BNE]  = 1'b1; src_a_d = rd_d; src_b_d = rs_d; end
            5'b00011: class_d[C_JAL] = 1'b1;
            5'b00100: begin class_d[C_JR]   = 1'b1; src_a_d = rd_d; end
            5'b00110: begin class_d[C_BLT]  = 1'b1; src_a_d = rd_d; src_b_d = rs_d; end
            5'b10110: begin class_d[C_BEX]  = 1'b1; src_a_d = REG_STATUS; end
            5'b10101: class_d[C_SETX] = 1'b1;
            default:  illegal_d = 1'b1;
        endcase
    end

    // pipeline register
    logic                    valid_q;
    logic [31:0]             pc_q;
    logic [REG_W-1:0]        opcode_q, rd_q, rs_q, rt_q, shamt_q, aluop_q;
    logic [DATA_WIDTH-1:0]   imm_q;
    logic [TARGET_WIDTH-1:0] target_q;
    logic [CLASS_W-1:0]      class_q;
    logic                    illegal_q;
    logic [REG_W-1:0]        src_a_q, src_b_q;

    // load-use interlock against the held entry; r0 never stalls
    logic hazard_c, out_valid_c, in_ready_c, accept_c, xfer_c;

    assign hazard_c    = valid_q && ex_load_valid && (ex_load_rd != '0) &&
                         ((ex_load_rd == src_a_q) || (ex_load_rd == src_b_q));
    assign out_valid_c = valid_q && !hazard_c;
    assign in_ready_c  = !valid_q || (bus.out_ready && !hazard_c);
    assign accept_c    = bus.in_valid && in_ready_c;
    assign xfer_c      = out_valid_c && bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            shamt_q   <= '0;
            aluop_q   <= '0;
            imm_q     <= '0;
            target_q  <= '0;
            class_q   <= '0;
            illegal_q <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept_c) begin
            valid_q   <= 1'b1;
            pc_q      <= bus.in_pc;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            shamt_q   <= shamt_d;
            aluop_q   <= aluop_d;
            imm_q     <= imm_d;
            target_q  <= target_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
        end else if (xfer_c) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = pc_q;
    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs        = rs_q;
    assign bus.rt        = rt_q;
    assign bus.shamt     = shamt_q;
    assign bus.aluop     = aluop_q;
    assign bus.imm       = imm_q;
    assign bus.target    = target_q;
    assign bus.op_class  = class_q;
    assign bus.illegal   = illegal_q;
    assign bus.src_a     = src_a_q;
    assign bus.src_b     = src_b_q;
endmodule
